// File: rtl/mul_unit.sv
// rtl/mul_unit.sv - RV32M multiply-group front end for the shared sequential multiplier
//
// Accepts one MUL/MULH/MULHSU/MULHU micro-op at a time, derives operand sign
// controls, runs the multiplier operand/product handshakes, selects the low
// or high product word and holds the result for writeback.
//
// Optional feature macro: MUL_ZERO_SKIP_EN
//   defined   : a zero operand bypasses the multiplier, result 0 one cycle later
//   undefined : every operation goes through the multiplier
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   flush                 kills the in-flight operation
//   in_valid/in_ready     micro-op handshake from issue
//   in_func3/in_rd        funct3 (bits [1:0] used), destination register
//   in_src1/in_src2       rs1/rs2 values
//   mul_flush             flush forwarded to the multiplier
//   mul_in_valid/_ready   operand handshake to the multiplier
//   mul_in_sign           [1] a signed, [0] b signed
//   mul_in_a/mul_in_b     latched operands
//   mul_out_valid/_ready  product handshake from the multiplier
//   mul_out_prod          64-bit product
//   out_valid/out_ready   result handshake to writeback
//   out_rd/out_data       latched destination register and result word

module mul_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_func3,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_src1,
  input  logic [31:0] in_src2,
  output logic        mul_flush,
  output logic        mul_in_valid,
  input  logic        mul_in_ready,
  output logic [1:0]  mul_in_sign,
  output logic [31:0] mul_in_a,
  output logic [31:0] mul_in_b,
  input  logic        mul_out_valid,
  output logic        mul_out_ready,
  input  logic [63:0] mul_out_prod,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_rd,
  output logic [31:0] out_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  state_t      w_accept_target;
  logic [1:0]  r_op;
  logic [4:0]  r_rd;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_result;
  logic        w_accept;
  logic        w_capture;
  logic [1:0]  w_sign;
  logic        w_unused_func3;

  assign w_unused_func3 = in_func3[2];

`ifdef MUL_ZERO_SKIP_EN
  logic w_zero;
  assign w_zero          = (in_src1 == 32'd0) || (in_src2 == 32'd0);
  assign w_accept_target = w_zero ? S_DONE : S_ISSUE;
`else
  assign w_accept_target = S_ISSUE;
`endif

  // A new op may enter while the previous result retires in the same cycle.
  assign in_ready      = ((r_state == S_IDLE) || ((r_state == S_DONE) && out_ready)) && !flush;
  assign w_accept      = in_valid && in_ready;
  assign mul_flush     = flush;
  assign mul_in_valid  = (r_state == S_ISSUE) && !flush;
  assign mul_out_ready = (r_state == S_WAIT) && !flush;
  assign out_valid     = (r_state == S_DONE) && !flush;
  assign w_capture     = mul_out_valid && mul_out_ready;

  // MUL/MULH: both signed; MULHSU: only a signed; MULHU: neither.
  // MUL needs only the low word, which is sign-independent, so it shares MULH's setting.
  assign w_sign[1] = ~(r_op[1] & r_op[0]);
  assign w_sign[0] = ~r_op[1];

  // No operation is held in IDLE, so sign controls rest at zero there.
  assign mul_in_sign = (r_state == S_IDLE) ? 2'b00 : w_sign;
  assign mul_in_a    = r_a;
  assign mul_in_b    = r_b;
  assign out_rd      = r_rd;
  assign out_data    = r_result;

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) w_next = w_accept_target;
        end
        S_ISSUE: begin
          if (mul_in_ready) w_next = S_WAIT;
        end
        S_WAIT: begin
          if (w_capture) w_next = S_DONE;
        end
        S_DONE: begin
          if (w_accept) begin
            w_next = w_accept_target;
          end else if (out_ready) begin
            w_next = S_IDLE;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_op     <= 2'b00;
      r_rd     <= 5'd0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_result <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op <= in_func3[1:0];
        r_rd <= in_rd;
        r_a  <= in_src1;
        r_b  <= in_src2;
`ifdef MUL_ZERO_SKIP_EN
        if (w_zero) r_result <= 32'd0;
`endif
      end
      // Accept and capture never coincide: they belong to different states.
      if (w_capture) begin
        r_result <= (r_op == 2'b00) ? mul_out_prod[31:0] : mul_out_prod[63:32];
      end
    end
  end

endmodule

// File: tb/tb_mul_unit.sv
// tb/tb_mul_unit.sv - scoreboard bench for mul_unit with a behavioural multiplier

module tb_mul_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_func3;
  logic [4:0]  in_rd;
  logic [31:0] in_src1;
  logic [31:0] in_src2;
  logic        mul_flush;
  logic        mul_in_valid;
  logic        mul_in_ready;
  logic [1:0]  mul_in_sign;
  logic [31:0] mul_in_a;
  logic [31:0] mul_in_b;
  logic        mul_out_valid;
  logic        mul_out_ready;
  logic [63:0] mul_out_prod;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd;
  logic [31:0] out_data;

`ifdef MUL_ZERO_SKIP_EN
  localparam int ZLAT = 1;
  localparam bit ZSKIP = 1'b1;
`else
  localparam int ZLAT = 19;
  localparam bit ZSKIP = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stall_req = 0;
  int exp_lat = -1;
  logic or_drv;
  logic or_rand = 1'b1;
  logic rand_mode;

  assign out_ready = rand_mode ? or_rand : or_drv;

  mul_unit dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_func3(in_func3), .in_rd(in_rd),
    .in_src1(in_src1), .in_src2(in_src2),
    .mul_flush(mul_flush), .mul_in_valid(mul_in_valid), .mul_in_ready(mul_in_ready),
    .mul_in_sign(mul_in_sign), .mul_in_a(mul_in_a), .mul_in_b(mul_in_b),
    .mul_out_valid(mul_out_valid), .mul_out_ready(mul_out_ready), .mul_out_prod(mul_out_prod),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_data(out_data)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc++;
    or_rand <= 1'($urandom_range(0, 1));
  end

  // Sequential multiplier model: 17 cycles from operand handshake to product.
  logic        m_busy = 1'b0;
  int          m_cnt = 0;
  int          m_wait = 0;
  logic [63:0] m_prod = 64'd0;

  function automatic logic [63:0] ext(input logic s, input logic [31:0] v);
    return s ? {{32{v[31]}}, v} : {32'd0, v};
  endfunction

  assign mul_in_ready  = !m_busy && (m_wait >= stall_req);
  assign mul_out_valid = m_busy && (m_cnt == 0);
  assign mul_out_prod  = m_prod;

  always @(posedge clock) begin
    if (reset || mul_flush) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_wait <= 0;
    end else if (mul_in_valid && mul_in_ready) begin
      m_busy <= 1'b1;
      m_cnt  <= 16;
      m_wait <= 0;
      m_prod <= ext(mul_in_sign[1], mul_in_a) * ext(mul_in_sign[0], mul_in_b);
    end else begin
      if (mul_in_valid) m_wait <= m_wait + 1;
      if (m_busy && m_cnt != 0) m_cnt <= m_cnt - 1;
      if (mul_out_valid && mul_out_ready) m_busy <= 1'b0;
    end
  end

  // Reference: RV32M results from integer arithmetic.
  function automatic logic [31:0] ref_result(input logic [1:0] f, input logic [31:0] x, input logic [31:0] y);
    longint          sx = longint'($signed(x));
    longint          sy = longint'($signed(y));
    longint          uy = longint'({32'd0, y});
    longint unsigned ux = longint'({32'd0, x});
    logic [63:0]     p;
    case (f)
      2'd0:    p = sx * sy;
      2'd1:    p = sx * sy;
      2'd2:    p = sx * uy;
      default: p = ux * longint'(uy);
    endcase
    return (f == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [1:0] ref_sign(input logic [1:0] f);
    case (f)
      2'd0, 2'd1: return 2'b11;
      2'd2:       return 2'b10;
      default:    return 2'b00;
    endcase
  endfunction

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  sign;
    int          t;
    int          lat;
    bit          zs;
  } ent_t;

  ent_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor_loop();
    ent_t e;
    ent_t n;
    bit   iss_seen = 0;
    bit   out_seen = 0;
    forever begin
      @(negedge clock);
      if (reset) continue;
      if (flush) begin
        chk("flush_out_valid", out_valid, 0);
        chk("flush_mul_in_valid", mul_in_valid, 0);
        chk("flush_mul_out_ready", mul_out_ready, 0);
        chk("flush_in_ready", in_ready, 0);
        chk("flush_mul_flush", mul_flush, 1);
        sb.delete();
        iss_seen = 0;
        out_seen = 0;
        continue;
      end
      chk("mul_flush_low", mul_flush, 0);
      if (sb.size() != 0) begin
        e = sb[0];
        if (e.zs) begin
          chk("zskip_no_issue", mul_in_valid, 0);
        end else if (mul_in_valid) begin
          chk("mul_in_a", mul_in_a, e.a);
          chk("mul_in_b", mul_in_b, e.b);
          chk("mul_in_sign", mul_in_sign, e.sign);
          if (!iss_seen) begin
            iss_seen = 1;
            chk("issue_delay", cyc - e.t, 1);
          end
        end
        if (out_valid) begin
          if (!out_seen) begin
            out_seen = 1;
            if (e.lat >= 0) chk("out_latency", cyc - e.t, e.lat);
          end
          chk("out_rd", out_rd, e.rd);
          chk("out_data", out_data, e.data);
          if (out_ready) begin
            void'(sb.pop_front());
            iss_seen = 0;
            out_seen = 0;
          end
        end
      end else begin
        chk("spurious_out_valid", out_valid, 0);
        chk("spurious_issue", mul_in_valid, 0);
      end
      if (in_valid && in_ready) begin
        n.rd   = in_rd;
        n.data = ref_result(in_func3[1:0], in_src1, in_src2);
        n.a    = in_src1;
        n.b    = in_src2;
        n.sign = ref_sign(in_func3[1:0]);
        n.t    = cyc;
        n.lat  = exp_lat;
        n.zs   = ZSKIP && (in_src1 == 32'd0 || in_src2 == 32'd0);
        sb.push_back(n);
      end
    end
  endtask

  task automatic send(input logic [2:0] f, input logic [4:0] rd, input logic [31:0] x,
                      input logic [31:0] y, input int lat, input int stall, input bit must_now);
    bit acc = 0;
    stall_req = stall;
    exp_lat   = lat;
    in_valid  = 1'b1;
    in_func3  = f;
    in_rd     = rd;
    in_src1   = x;
    in_src2   = y;
    for (int k = 0; k < 300; k++) begin
      @(negedge clock);
      if (in_ready) begin
        acc = 1;
        if (must_now) chk("b2b_accept_wait", k, 0);
        break;
      end
    end
    chk("accept_timeout", acc, 1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_func3 = 3'($urandom);
    in_rd    = 5'($urandom);
    in_src1  = $urandom;
    in_src2  = $urandom;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clock);
      if (sb.size() == 0) begin
        done = 1;
        break;
      end
    end
    chk("drain_timeout", done, 1);
    @(posedge clock);
    #1;
  endtask

  task automatic wait_out_valid();
    bit seen = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (out_valid) begin
        seen = 1;
        break;
      end
    end
    chk("out_valid_timeout", seen, 1);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_func3 = 3'd0; in_rd = 5'd0;
    in_src1 = 32'd0; in_src2 = 32'd0; or_drv = 1'b1; rand_mode = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_mul_in_valid", mul_in_valid, 0);
    chk("rst_mul_out_ready", mul_out_ready, 0);
    chk("rst_mul_in_sign", mul_in_sign, 0);
    chk("rst_mul_in_a", mul_in_a, 0);
    chk("rst_mul_in_b", mul_in_b, 0);
    chk("rst_out_rd", out_rd, 0);
    chk("rst_out_data", out_data, 0);
    fork
      monitor_loop();
    join_none
    @(posedge clock);
    #1 reset = 1'b0;

    send(3'b000, 5'd5, 32'd7, 32'hFFFF_FFFD, 19, 0, 0);
    wait_idle();
    for (int f = 1; f < 4; f++) begin
      send(3'(f), 5'(10 + f), 32'h8000_0000, 32'hFFFF_FFFF, 19, 0, 0);
      wait_idle();
    end

    // Result held under writeback backpressure, then retired alongside a new accept.
    or_drv = 1'b0;
    send(3'b001, 5'd9, 32'h1234_5678, 32'h9ABC_DEF1, 19, 0, 0);
    wait_out_valid();
    repeat (5) @(negedge clock);
    @(posedge clock);
    #1 or_drv = 1'b1;
    send(3'b010, 5'd17, 32'hDEAD_BEEF, 32'h0000_0101, 19, 0, 1);
    wait_idle();

    // Flush ten cycles after accept, then a fresh op.
    send(3'b000, 5'd3, 32'h0000_1111, 32'h0000_2222, -1, 0, 0);
    repeat (9) @(posedge clock);
    #1 flush = 1'b1;
    @(posedge clock);
    #1 flush = 1'b0;
    @(negedge clock);
    chk("in_ready_after_flush", in_ready, 1);
    chk("out_valid_after_flush", out_valid, 0);
    @(posedge clock);
    #1;
    send(3'b000, 5'd12, 32'd3, 32'd4, 19, 0, 0);
    wait_idle();

    // Flush while the result waits in DONE with writeback ready.
    or_drv = 1'b0;
    send(3'b011, 5'd20, 32'hFFFF_0000, 32'h0001_0001, -1, 0, 0);
    wait_out_valid();
    @(posedge clock);
    #1 flush = 1'b1; or_drv = 1'b1;
    @(posedge clock);
    #1 flush = 1'b0;
    repeat (3) @(posedge clock);
    #1;

    // Operand stall of three cycles lengthens latency by three.
    send(3'b000, 5'd21, 32'h0F0F_0F0F, 32'h0000_0033, 22, 3, 0);
    wait_idle();

    // Zero operand.
    send(3'b011, 5'd7, 32'd0, 32'd5, ZLAT, 0, 0);
    wait_idle();

    rand_mode = 1'b1;
    repeat (40) begin
      logic [31:0] x;
      logic [31:0] y;
      x = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      y = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      send(3'($urandom_range(0, 7)), 5'($urandom), x, y, -1, $urandom_range(0, 2), 0);
    end
    wait_idle();
    rand_mode = 1'b0;
    stall_req = 0;
    repeat (3) @(posedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
